// File: rtl/approx_mult_pkg.sv
// Shared definitions for the approximate pipelined multiplier: column sizing,
// pipeline depth and the OR-based 4:2 compressor truth function.
package approx_mult_pkg;

    localparam int unsigned PIPE_STAGES = 3;

    // Number of partial-product bits that land in column j of an n x n array.
    function automatic int unsigned pp_col_count(input int unsigned j, input int unsigned n);
        if (j >= 2*n - 1) return 0;
        if (j < n) return j + 1;
        return 2*n - 1 - j;
    endfunction

    // Returns {carry, sum}; carry has twice the weight of sum, no chain between groups.
    function automatic logic [1:0] comp42(input logic x1, input logic x2,
                                          input logic x3, input logic x4);
        return {(x1 & x2) | (x3 & x4), (x1 ^ x2) | (x3 ^ x4)};
    endfunction

endpackage

// File: rtl/approx_mult_pipe_comp42.sv
// Approximate 4:2 compressor for one group of four column bits.
module approx_comp42
    import approx_mult_pkg::*;
(
    input  logic x1,
    input  logic x2,
    input  logic x3,
    input  logic x4,
    output logic sum,
    output logic carry
);

    assign {carry, sum} = comp42(x1, x2, x3, x4);

endmodule

// File: rtl/approx_mult_pipe.sv
// Three-stage unsigned NxN multiplier with per-beat exact/approximate mode,
// valid/ready on both sides and a saturating count of approximate beats.
module approx_mult_pipe
    import approx_mult_pkg::*;
#(
    parameter int unsigned N           = 8,
    parameter int unsigned APPROX_COLS = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N-1:0]   in_a,
    input  logic [N-1:0]   in_b,
    input  logic           in_mode,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*N-1:0] out_p,
    output logic           out_mode,
    output logic [31:0]    approx_cnt
);

    localparam int unsigned PW  = 2*N;
    localparam int unsigned ACE = (APPROX_COLS > PW) ? PW : APPROX_COLS;
    localparam int unsigned ACW = (ACE == 0) ? 1 : ACE;
    localparam int unsigned G   = (N + 3) / 4;
    localparam logic [PW-1:0] LOW_MASK = (ACE == 0) ? '0 : ({PW{1'b1}} >> (PW - ACE));

    logic          advance;
    logic          v1_q, v2_q, v3_q;
    logic          mode1_q, mode2_q, mode3_q;
    logic [N-1:0]  a_q, b_q;
    logic [PW-1:0] row_s_q, row_c_q, row_s_d, row_c_d;
    logic [PW-1:0] p_q, p_d;
    logic [31:0]   cnt_q, cnt_d;
    logic [PW-1:0] ex_mask, pp_row, grp_sv, grp_cv;
    logic [ACW*G-1:0] grp_s, grp_c;

    function automatic logic [2*PW-1:0] csa(input logic [PW-1:0] s, input logic [PW-1:0] c,
                                             input logic [PW-1:0] r);
        logic [PW-1:0] maj;
        maj = (s & c) | (s & r) | (c & r);
        return {maj[PW-2:0], 1'b0, s ^ c ^ r};
    endfunction

    assign advance    = !v3_q || out_ready;
    assign in_ready   = advance;
    assign out_valid  = v3_q;
    assign out_p      = p_q;
    assign out_mode   = mode3_q;
    assign approx_cnt = cnt_q;

    // Group g of column j is flattened to index j*G+g; absent groups read as zero.
    if (ACE == 0) begin : g_no_approx
        assign grp_s = '0;
        assign grp_c = '0;
    end else begin : g_approx
        for (genvar j = 0; j < ACE; j++) begin : g_col
            localparam int unsigned ILO = (j >= N) ? j - N + 1 : 0;
            localparam int unsigned CNT = pp_col_count(j, N);
            for (genvar g = 0; g < G; g++) begin : g_grp
                if (4*g < CNT) begin : g_live
                    logic [3:0] x;
                    for (genvar m = 0; m < 4; m++) begin : g_bit
                        if (4*g + m < CNT) begin : g_pp
                            assign x[m] = a_q[j - ILO - 4*g - m] & b_q[ILO + 4*g + m];
                        end else begin : g_pad
                            assign x[m] = 1'b0;
                        end
                    end
                    approx_comp42 u_comp (
                        .x1    (x[0]),
                        .x2    (x[1]),
                        .x3    (x[2]),
                        .x4    (x[3]),
                        .sum   (grp_s[j*G + g]),
                        .carry (grp_c[j*G + g])
                    );
                end else begin : g_none
                    assign grp_s[j*G + g] = 1'b0;
                    assign grp_c[j*G + g] = 1'b0;
                end
            end
        end
    end

    // Carry-save fold of exact rows plus approximate group vectors into two rows.
    always_comb begin
        ex_mask = mode1_q ? ~LOW_MASK : '1;
        row_s_d = '0;
        row_c_d = '0;
        pp_row  = '0;
        grp_sv  = '0;
        grp_cv  = '0;
        for (int unsigned i = 0; i < N; i++) begin
            pp_row         = '0;
            pp_row[N-1:0]  = a_q & {N{b_q[i]}};
            pp_row         = (pp_row << i) & ex_mask;
            {row_c_d, row_s_d} = csa(row_s_d, row_c_d, pp_row);
        end
        for (int unsigned g = 0; g < G; g++) begin
            grp_sv = '0;
            grp_cv = '0;
            for (int unsigned j = 0; j < ACW; j++) begin
                grp_sv[j] = grp_s[j*G + g];
                if (j + 1 < PW) grp_cv[j+1] = grp_c[j*G + g];
            end
            if (mode1_q) begin
                {row_c_d, row_s_d} = csa(row_s_d, row_c_d, grp_sv);
                {row_c_d, row_s_d} = csa(row_s_d, row_c_d, grp_cv);
            end
        end
    end

    assign p_d = row_s_q + row_c_q;

    always_comb begin
        cnt_d = cnt_q;
        if (in_valid && advance && in_mode && (cnt_q != '1)) cnt_d = cnt_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q    <= 1'b0;
            v2_q    <= 1'b0;
            v3_q    <= 1'b0;
            mode1_q <= 1'b0;
            mode2_q <= 1'b0;
            mode3_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            row_s_q <= '0;
            row_c_q <= '0;
            p_q     <= '0;
            cnt_q   <= '0;
        end else begin
            cnt_q <= cnt_d;
            if (advance) begin
                v1_q <= in_valid;
                v2_q <= v1_q;
                v3_q <= v2_q;
                if (in_valid) begin
                    a_q     <= in_a;
                    b_q     <= in_b;
                    mode1_q <= in_mode;
                end
                if (v1_q) begin
                    row_s_q <= row_s_d;
                    row_c_q <= row_c_d;
                    mode2_q <= mode1_q;
                end
                if (v2_q) begin
                    p_q     <= p_d;
                    mode3_q <= mode2_q;
                end
            end
        end
    end

endmodule

// File: tb/tb_approx_mult_pipe.sv
// Bench for approx_mult_pipe: directed table, randomized streaming with stalls,
// mid-flight reset and counter saturation, against a column-wise reference model.
module tb_approx_mult_pipe;

    localparam int unsigned TN = 8;

    logic          clk, rst, in_valid, in_mode, out_ready;
    logic [TN-1:0] in_a, in_b;
    logic          in_ready, out_valid, out_mode;
    logic [2*TN-1:0] out_p;
    logic [31:0]   approx_cnt;
    logic          in_ready0, out_valid0, out_mode0;
    logic [2*TN-1:0] out_p0;
    logic [31:0]   approx_cnt0;

    int n_vec = 0;
    int n_err = 0;

    typedef struct packed { logic [2*TN-1:0] p; logic m; } exp_t;
    exp_t q1[$];
    exp_t q0[$];
    logic [31:0] cnt1, cnt0;

    typedef struct { logic [TN-1:0] a; logic [TN-1:0] b; logic mode; logic [2*TN-1:0] p; } vec_t;
    vec_t tbl[8];

    approx_mult_pipe #(.N(TN), .APPROX_COLS(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_mode(in_mode), .out_valid(out_valid),
        .out_ready(out_ready), .out_p(out_p), .out_mode(out_mode), .approx_cnt(approx_cnt)
    );

    approx_mult_pipe #(.N(TN), .APPROX_COLS(0)) dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0),
        .in_a(in_a), .in_b(in_b), .in_mode(in_mode), .out_valid(out_valid0),
        .out_ready(out_ready), .out_p(out_p0), .out_mode(out_mode0), .approx_cnt(approx_cnt0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Column-by-column evaluation straight from the partial-product definition.
    function automatic logic [2*TN-1:0] golden(input int unsigned a, input int unsigned b,
                                               input bit mode, input int unsigned ac);
        longint unsigned acc;
        int unsigned bits[$];
        int unsigned s, c;
        acc = 0;
        for (int j = 0; j < 2*TN; j++) begin
            bits.delete();
            for (int i = 0; i < TN; i++) begin
                int k;
                k = j - i;
                if (k >= 0 && k < TN) bits.push_back(((a >> k) & 1) & ((b >> i) & 1));
            end
            if (mode && j < int'(ac)) begin
                while (bits.size() % 4 != 0) bits.push_back(0);
                for (int g = 0; g < bits.size(); g += 4) begin
                    s = (bits[g] ^ bits[g+1]) | (bits[g+2] ^ bits[g+3]);
                    c = (bits[g] & bits[g+1]) | (bits[g+2] & bits[g+3]);
                    acc += 64'(s) << j;
                    acc += 64'(c) << (j + 1);
                end
            end else begin
                foreach (bits[x]) acc += 64'(bits[x]) << j;
            end
        end
        return acc[2*TN-1:0];
    endfunction

    function automatic logic [TN-1:0] rand_op();
        int unsigned r;
        r = $urandom_range(7);
        if (r == 0) return '1;
        if (r == 1) return '0;
        return TN'($urandom_range(255));
    endfunction

    // Scoreboard: every accepted beat is queued, every presented product checked.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            q1.delete();
            q0.delete();
            cnt1 = '0;
            cnt0 = '0;
        end else begin
            chk("in_ready", in_ready, !(out_valid && !out_ready));
            chk("in_ready0", in_ready0, !(out_valid0 && !out_ready));
            chk("approx_cnt", approx_cnt, cnt1);
            chk("approx_cnt0", approx_cnt0, cnt0);
            if (out_valid) begin
                if (q1.size() == 0) chk("spurious_out", out_valid, 0);
                else begin
                    chk("out_p", out_p, q1[0].p);
                    chk("out_mode", out_mode, q1[0].m);
                    if (out_ready) void'(q1.pop_front());
                end
            end
            if (out_valid0) begin
                if (q0.size() == 0) chk("spurious_out0", out_valid0, 0);
                else begin
                    chk("out_p0", out_p0, q0[0].p);
                    chk("out_mode0", out_mode0, q0[0].m);
                    if (out_ready) void'(q0.pop_front());
                end
            end
            if (in_valid && in_ready) begin
                e.p = golden(in_a, in_b, in_mode, 8);
                e.m = in_mode;
                q1.push_back(e);
                if (in_mode && cnt1 != 32'hFFFF_FFFF) cnt1 = cnt1 + 1;
            end
            if (in_valid && in_ready0) begin
                e.p = golden(in_a, in_b, in_mode, 0);
                e.m = in_mode;
                q0.push_back(e);
                if (in_mode && cnt0 != 32'hFFFF_FFFF) cnt0 = cnt0 + 1;
            end
        end
    end

    // Entered just after a rising edge; returns at the falling edge where the product shows.
    task automatic send_one(input logic [TN-1:0] a, input logic [TN-1:0] b, input logic mode,
                            output int lat, output logic [2*TN-1:0] p, output logic m);
        in_a = a;
        in_b = b;
        in_mode = mode;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (lat < 10) begin
            lat++;
            @(negedge clk);
            if (out_valid) break;
        end
        p = out_p;
        m = out_mode;
    endtask

    task automatic stream(input int nbeats, input int msel, input int vpct, input int rpct);
        int sent = 0;
        int cyc = 0;
        while (sent < nbeats && cyc < nbeats*20 + 100) begin
            in_a = rand_op();
            in_b = rand_op();
            in_mode = (msel == 2) ? ($urandom_range(1) != 0) : msel[0];
            in_valid = ($urandom_range(99) < vpct);
            out_ready = ($urandom_range(99) < rpct);
            @(negedge clk);
            if (in_valid && in_ready) sent++;
            @(posedge clk); #1;
            cyc++;
        end
        chk("stream_sent", sent, nbeats);
        in_valid = 1'b0;
        out_ready = 1'b1;
        cyc = 0;
        while ((q1.size() != 0 || q0.size() != 0) && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("drain", q1.size() + q0.size(), 0);
    endtask

    initial begin
        int lat;
        logic [2*TN-1:0] p;
        logic m;
        int unsigned tcnt;

        tbl[0] = '{8'd255, 8'd255, 1'b0, 16'd65025};
        tbl[1] = '{8'd255, 8'd255, 1'b1, 16'd64273};
        tbl[2] = '{8'd3,   8'd3,   1'b1, 16'd9};
        tbl[3] = '{8'd15,  8'd15,  1'b1, 16'd209};
        tbl[4] = '{8'd128, 8'd128, 1'b1, 16'd16384};
        tbl[5] = '{8'd255, 8'd1,   1'b1, 16'd255};
        tbl[6] = '{8'd0,   8'd200, 1'b1, 16'd0};
        tbl[7] = '{8'd12,  8'd10,  1'b0, 16'd120};

        rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_mode = 1'b0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_p", out_p, 0);
        chk("rst_out_mode", out_mode, 0);
        chk("rst_approx_cnt", approx_cnt, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid0", out_valid0, 0);
        @(posedge clk); #1;

        tcnt = 0;
        for (int i = 0; i < 8; i++) begin
            send_one(tbl[i].a, tbl[i].b, tbl[i].mode, lat, p, m);
            if (tbl[i].mode) tcnt++;
            chk("tbl_latency", lat, 3);
            chk("tbl_out_p", p, tbl[i].p);
            chk("tbl_out_mode", m, tbl[i].mode);
            chk("tbl_approx_cnt", approx_cnt, tcnt);
            @(posedge clk); #1;
        end

        stream(1000, 0, 100, 100);
        stream(1000, 1, 100, 100);
        stream(500, 2, 70, 50);

        // Three beats in flight, then a one-cycle reset with a fresh beat presented.
        out_ready = 1'b1;
        in_mode = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_a = rand_op();
            in_b = rand_op();
            in_valid = 1'b1;
            @(posedge clk); #1;
        end
        rst = 1'b1;
        in_a = 8'd200;
        in_b = 8'd201;
        @(posedge clk); #1;
        rst = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        chk("post_rst_out_valid", out_valid, 0);
        chk("post_rst_approx_cnt", approx_cnt, 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("post_rst_stale", out_valid, 0);
        end
        @(posedge clk); #1;
        send_one(8'd7, 8'd9, 1'b1, lat, p, m);
        chk("post_rst_latency", lat, 3);
        chk("post_rst_out_p", p, 16'd63);
        chk("post_rst_cnt", approx_cnt, 1);
        @(posedge clk); #1;

        force dut.cnt_q = 32'hFFFF_FFFD;
        cnt1 = 32'hFFFF_FFFD;
        #1 release dut.cnt_q;
        @(posedge clk); #1;
        stream(4, 1, 100, 100);
        chk("cnt_saturate", approx_cnt, 32'hFFFF_FFFF);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/approx_mult_pipe.md
# approx_mult_pipe

Parametrised, pipelined unsigned N×N multiplier with a runtime-selectable approximate mode. In approximate mode, the partial-product bits in the low APPROX_COLS columns are reduced by a fixed OR-based 4:2 approximate compressor; all other columns use exact reduction. It is the next-generation datapath built around our approximate 4:2 compressor work, with valid/ready handshaking on both sides so it can drop into streaming DSP paths.

## Interface
- N, 8: operand width (≥4); product width is 2N.
- APPROX_COLS, 8: number of low columns (0..2N-1) that are approximated when mode=1; 0 gives an always-exact multiplier.

- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  operand beat valid
- in_ready  out  1  block can accept a beat this cycle
- in_a  in  N  multiplicand, unsigned
- in_b  in  N  multiplier, unsigned
- in_mode  in  1  0 = exact, 1 = approximate
- out_valid  out  1  product valid
- out_ready  in  1  downstream accepts product
- out_p  out  2N  product
- out_mode  out  1  in_mode echoed for this product
- approx_cnt  out  32  count of accepted mode=1 beats, saturating

## Operation
- Partial products: p(i,k) = a[k] & b[i], placed in column j = i+k.
- Exact columns (j ≥ APPROX_COLS, or any column when mode=0): summed exactly.
- Approximate column j (j < APPROX_COLS, mode=1):
  - Order the column bits by ascending i.
  - Group them in fours as x1..x4, zero-padding the last group.
  - Each group yields s = (x1^x2)|(x3^x4), weight 2^j, and c = (x1&x2)|(x3&x4), weight 2^(j+1).
  - There is no carry-in or carry-out between groups.
- Golden model: out_p = Σ(exact-column bits·2^j) + Σ(group s·2^j + c·2^(j+1)), taken mod 2^(2N).
- Any internal tree is allowed for the exact portion, provided it matches the golden model bit-exactly.
- Handshake:
  - Beat accepted when in_valid & in_ready.
  - Product delivered when out_valid & out_ready.
  - While out_valid=1, out_p and out_mode are held stable until accepted.
- Stall: advance = !out_valid | out_ready.
  - When advance is high, the whole pipe shifts one stage.
  - When advance is low, all stages hold.
  - in_ready = advance; it is combinational from out_ready and out_valid.
- Bubbles are not compressed. An empty stage inside the pipe travels forward like data.
- approx_cnt increments on each accepted beat with in_mode=1. It stops at 0xFFFF_FFFF.

## Timing
- Three register stages:
  - S1: registers operands and mode, then generates partial products.
  - S2: registers the compressed two-row result (approximate groups plus exact reduction).
  - S3: registers the final carry-propagate sum into out_p.
- Latency: a beat accepted in cycle t appears with out_valid=1 in cycle t+3 if advance held continuously.
- Throughput: one beat per cycle while out_ready=1.
- Reset, applied while rst=1 and effective on the next edge:
  - all stage valid bits = 0, out_valid = 0, out_p = 0, out_mode = 0, approx_cnt = 0;
  - in_ready = 1 after reset, since out_valid = 0.
- Reset mid-operation: in-flight beats are discarded with no output. A beat presented on a cycle with rst=1 is not accepted and not counted.
- Simultaneous output accept and input accept in the same cycle is legal and required for full rate.
- A mode change between consecutive beats takes effect per beat. There is no pipeline flush.

## Structure
- Shared package approx_mult_pkg holds:
  - function pp_col_count(j, N), the bit count of column j;
  - localparam PIPE_STAGES = 3;
  - the approximate compressor truth definition, as a function used by RTL and the bench model.
- Sub-module approx_comp42: inputs x1..x4, outputs sum and carry, purely combinational per the formulas above. It is instantiated once per group in approximate columns.
- Top level handles partial products, the exact reduction tree, mode muxing, the pipeline registers, the handshake and the counter.

## Test plan
- mode=0, N=8, a=255, b=255 -> out_p=65025 three cycles after acceptance; approx_cnt stays 0.
- mode=1, APPROX_COLS=8, a=255, b=255 -> out_p=64273; approx_cnt=1.
- mode=1, a=3, b=3 -> out_p=9 (approximation is exact for this input); 1000 random beats in each mode compared against the golden model.
- Continuous streaming with out_ready toggled pseudo-randomly:
  - no loss or duplication, in order;
  - out_p stable while stalled;
  - in_ready=0 exactly when out_valid=1 and out_ready=0.
- rst asserted for one cycle with three beats in flight:
  - no stale outputs;
  - out_valid=0 and approx_cnt=0 after reset;
  - the next beat emerges with latency 3.
- APPROX_COLS=0 build with mode=1 traffic -> results always exact; the counter still increments. approx_cnt preloaded near saturation via a force saturates at 0xFFFF_FFFF.
